// File: rtl/seq_gen_pkg.sv
// ============================================================================
// Module      : seq_gen_pkg
// Description : Shared state encoding and default widths for seq_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package seq_gen_pkg;

    localparam int c_PAT_W_DEFAULT = 4;
    localparam int c_CNT_W_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

`default_nettype wire

// File: rtl/piso_shreg.sv
// ============================================================================
// Module      : piso_shreg
// Description : Parallel-in serial-out shift register, MSB presented first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module piso_shreg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             msb
);

    logic [WIDTH-1:0] r_data;

    // Load has priority so a reload on the last bit of a copy needs no bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= r_data << 1;
        end
    end

    assign msb = r_data[WIDTH-1];

endmodule

`default_nettype wire

// File: rtl/seq_pattern_gen.sv
// ============================================================================
// Module      : seq_pattern_gen
// Description : Emits a latched bit pattern MSB-first, repeated with optional
//               zero gaps between copies; Moore FSM with registered outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_pattern_gen
    import seq_gen_pkg::*;
#(
    parameter int PAT_W = c_PAT_W_DEFAULT,
    parameter int CNT_W = c_CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [1:0]       gap_len,
    output logic             busy,
    output logic             out,
    output logic             out_valid,
    output logic             frame_done
);

    localparam int                 c_BIT_W    = (PAT_W > 1) ? $clog2(PAT_W) : 1;
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(PAT_W - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_ONE  = c_BIT_W'(1);
    localparam logic [CNT_W-1:0]   c_REP_ONE  = CNT_W'(1);

    state_t             r_state;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [CNT_W-1:0]   r_rep_left;
    logic [1:0]         r_gap_left;
    logic [1:0]         r_gap_len;
    logic [PAT_W-1:0]   r_pat;
    logic               r_busy;
    logic               r_out_valid;
    logic               r_frame_done;
    logic               r_shift_act;

    logic               w_load;
    logic               w_shift;
    logic [PAT_W-1:0]   w_load_data;
    logic               w_msb;

    // Shift-register control mirrors the FSM transitions below.
    always_comb begin
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_load_data = r_pat;
        case (r_state)
            IDLE: begin
                if (start && (repeat_cnt != '0)) begin
                    w_load      = 1'b1;
                    w_load_data = pattern;
                end
            end
            SHIFT: begin
                if (r_bit_cnt != '0) begin
                    w_shift = 1'b1;
                end else if ((r_rep_left > c_REP_ONE) && (r_gap_len == 2'd0)) begin
                    w_load = 1'b1;
                end
            end
            GAP: begin
                if (r_gap_left == 2'd0) begin
                    w_load = 1'b1;
                end
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_bit_cnt    <= '0;
            r_rep_left   <= '0;
            r_gap_left   <= 2'd0;
            r_gap_len    <= 2'd0;
            r_pat        <= '0;
            r_busy       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_frame_done <= 1'b0;
            r_shift_act  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_pat      <= pattern;
                        r_gap_len  <= gap_len;
                        r_rep_left <= repeat_cnt;
                        r_bit_cnt  <= c_BIT_LAST;
                        if (repeat_cnt == '0) begin
                            r_state      <= DONE;
                            r_frame_done <= 1'b1;
                        end else begin
                            r_state     <= SHIFT;
                            r_busy      <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_shift_act <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (r_bit_cnt != '0) begin
                        r_bit_cnt <= r_bit_cnt - c_BIT_ONE;
                    end else if (r_rep_left <= c_REP_ONE) begin
                        r_state      <= DONE;
                        r_busy       <= 1'b0;
                        r_out_valid  <= 1'b0;
                        r_shift_act  <= 1'b0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_rep_left <= r_rep_left - c_REP_ONE;
                        r_bit_cnt  <= c_BIT_LAST;
                        if (r_gap_len != 2'd0) begin
                            r_state     <= GAP;
                            r_gap_left  <= r_gap_len - 2'd1;
                            r_shift_act <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    if (r_gap_left == 2'd0) begin
                        r_state     <= SHIFT;
                        r_shift_act <= 1'b1;
                        r_bit_cnt   <= c_BIT_LAST;
                    end else begin
                        r_gap_left <= r_gap_left - 2'd1;
                    end
                end
                DONE: begin
                    r_state      <= IDLE;
                    r_frame_done <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    piso_shreg #(
        .WIDTH (PAT_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .shift (w_shift),
        .din   (w_load_data),
        .msb   (w_msb)
    );

    // Gap cycles are valid but must drive zero, hence the gating.
    assign out        = r_shift_act & w_msb;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign frame_done = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_seq_pattern_gen.sv
// ============================================================================
// Module      : tb_seq_pattern_gen
// Description : Directed self-checking bench for seq_pattern_gen.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_pattern_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [1:0] gap_len;
    logic       busy;
    logic       out;
    logic       out_valid;
    logic       frame_done;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_pattern_gen #(
        .PAT_W (4),
        .CNT_W (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .busy       (busy),
        .out        (out),
        .out_valid  (out_valid),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launches one frame and records valid bits, timing and a 1101 detector count.
    task automatic run_frame(input logic [3:0] pat, input logic [3:0] rep, input logic [1:0] gap,
                             input int mess_at, output logic [127:0] bits, output int nvalid,
                             output int done_cyc, output int busy_err, output int busy_hi,
                             output int det);
        logic [3:0] hist;
        int         len;
        bits = '0; nvalid = 0; done_cyc = -1; busy_err = 0; busy_hi = 0; det = 0;
        hist = 4'd0; len = 0;
        @(negedge clk);
        pattern = pat; repeat_cnt = rep; gap_len = gap; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if (busy !== out_valid) busy_err++;
            if (busy === 1'b1) busy_hi++;
            if (out_valid === 1'b1) begin
                bits = {bits[126:0], out};
                nvalid++;
                hist = {hist[2:0], out};
                len++;
                if (len >= 4 && hist == 4'b1101) begin
                    det++;
                    len = 0;
                end
            end
            if (frame_done === 1'b1) begin
                done_cyc = k;
                break;
            end
            if (k == mess_at) begin
                start = 1'b1; pattern = 4'b0000; repeat_cnt = 4'd5; gap_len = 2'd3;
            end else if (k == mess_at + 1) begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] bits;
        int           nv, dc, be, bh, det, cnt_fd, cnt_v;
        logic [7:0]   vv, fdv;

        rst = 1'b1; start = 1'b0; pattern = 4'd0; repeat_cnt = 4'd0; gap_len = 2'd0;
        #1;
        chk("reset_outputs", {60'd0, busy, out, out_valid, frame_done}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_outputs", {60'd0, busy, out, out_valid, frame_done}, 64'd0);

        // 1101 x3, no gap
        run_frame(4'b1101, 4'd3, 2'd0, -10, bits, nv, dc, be, bh, det);
        chk("r3g0_bits", {52'd0, bits[11:0]}, 64'hDDD);
        chk("r3g0_nvalid", 64'(nv), 64'd12);
        chk("r3g0_done_cyc", 64'(dc), 64'd13);
        chk("r3g0_busy_eq_valid", 64'(be), 64'd0);
        @(negedge clk);
        chk("r3g0_done_one_cycle", {63'd0, frame_done}, 64'd0);

        // 1101 x2, gap 2
        run_frame(4'b1101, 4'd2, 2'd2, -10, bits, nv, dc, be, bh, det);
        chk("r2g2_bits", {54'd0, bits[9:0]}, 64'h34D);
        chk("r2g2_nvalid", 64'(nv), 64'd10);
        chk("r2g2_done_cyc", 64'(dc), 64'd11);
        chk("r2g2_busy_eq_valid", 64'(be), 64'd0);

        // zero repeats
        run_frame(4'b1111, 4'd0, 2'd1, -10, bits, nv, dc, be, bh, det);
        chk("r0_nvalid", 64'(nv), 64'd0);
        chk("r0_done_cyc", 64'(dc), 64'd1);
        chk("r0_busy_never", 64'(bh), 64'd0);

        // single copy, gap setting unused
        run_frame(4'b0110, 4'd1, 2'd3, -10, bits, nv, dc, be, bh, det);
        chk("r1g3_bits", {60'd0, bits[3:0]}, 64'h6);
        chk("r1g3_nvalid", 64'(nv), 64'd4);
        chk("r1g3_done_cyc", 64'(dc), 64'd5);

        // asynchronous abort during the 2nd pattern bit
        @(negedge clk);
        pattern = 4'b1101; repeat_cnt = 4'd3; gap_len = 2'd0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("abort_bit1", {62'd0, out_valid, out}, 64'h3);
        @(negedge clk);
        chk("abort_bit2_busy", {63'd0, busy}, 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_async_clear", {60'd0, busy, out, out_valid, frame_done}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cnt_fd = 0; cnt_v = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) cnt_fd++;
            if (out_valid === 1'b1) cnt_v++;
        end
        chk("abort_no_done", 64'(cnt_fd), 64'd0);
        chk("abort_no_valid", 64'(cnt_v), 64'd0);
        run_frame(4'b1011, 4'd2, 2'd1, -10, bits, nv, dc, be, bh, det);
        chk("post_abort_bits", {55'd0, bits[8:0]}, 64'h16B);
        chk("post_abort_done_cyc", 64'(dc), 64'd10);

        // start re-pulsed with new inputs mid-frame
        run_frame(4'b1101, 4'd2, 2'd0, 3, bits, nv, dc, be, bh, det);
        chk("restart_bits", {56'd0, bits[7:0]}, 64'hDD);
        chk("restart_nvalid", 64'(nv), 64'd8);
        chk("restart_done_cyc", 64'(dc), 64'd9);

        // start held high across two frames
        @(negedge clk);
        pattern = 4'b1001; repeat_cnt = 4'd1; gap_len = 2'd0; start = 1'b1;
        @(posedge clk);
        vv = '0; fdv = '0;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            vv[k]  = out_valid;
            fdv[k] = frame_done;
        end
        start = 1'b0;
        chk("held_done_cyc5", {63'd0, fdv[5]}, 64'd1);
        chk("held_idle_cyc6", {63'd0, vv[6]}, 64'd0);
        chk("held_restart_cyc7", {63'd0, vv[7]}, 64'd1);
        cnt_fd = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                cnt_fd = 1;
                break;
            end
        end
        chk("held_second_done", 64'(cnt_fd), 64'd1);

        // loopback into a 1101 non-overlapping detector
        run_frame(4'b1101, 4'd4, 2'd1, -10, bits, nv, dc, be, bh, det);
        chk("loop_det_count", 64'(det), 64'd4);
        chk("loop_nvalid", 64'(nv), 64'd19);
        chk("loop_done_cyc", 64'(dc), 64'd20);

        // maximum repeat count, maximum gap
        run_frame(4'b1010, 4'd15, 2'd3, -10, bits, nv, dc, be, bh, det);
        chk("max_nvalid", 64'(nv), 64'd102);
        chk("max_done_cyc", 64'(dc), 64'd103);
        chk("max_busy_eq_valid", 64'(be), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/seq_pattern_gen.md
SEQ_PATTERN_GEN -- requirements
Module: seq_pattern_gen

Interface
REQ-001 Parameter PAT_W, default 4, pattern width in bits.
REQ-002 Parameter CNT_W, default 4, repeat-counter width.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous and active-high.
REQ-005 Port start  input  1  request to begin a frame; sampled only in IDLE.
REQ-006 Port pattern  input  PAT_W  bit pattern to emit MSB-first (e.g. 4'b1101); latched at accepted start.
REQ-007 Port repeat_cnt  input  CNT_W  number of pattern copies per frame; latched at accepted start.
REQ-008 Port gap_len  input  2  zero bits inserted between copies (0-3); latched at accepted start.
REQ-009 Port busy  output  1  high in SHIFT and GAP.
REQ-010 Port out  output  1  serial data bit.
REQ-011 Port out_valid  output  1  high when out carries a frame bit (pattern or gap).
REQ-012 Port frame_done  output  1  one-cycle pulse at end of frame.

Function
REQ-013 Moore FSM with states IDLE, SHIFT, GAP, DONE; all outputs decoded from state and registers only, never from inputs.
REQ-014 IDLE: out=0, out_valid=0, busy=0, frame_done=0.
REQ-015 IDLE with start=1 at edge N: latch inputs; repeat_cnt=0 -> DONE; otherwise -> SHIFT, bit counter=PAT_W-1, repeats_left=repeat_cnt.
REQ-016 SHIFT: out=shift-register MSB, out_valid=1, busy=1; shift left one bit per cycle for exactly PAT_W cycles per copy.
REQ-017 First pattern bit appears in the cycle after edge N (latency 1 clock).
REQ-018 End of copy with repeats_left=1 -> DONE.
REQ-019 End of copy with repeats_left>1 and gap_len=0 -> reload pattern, stay in SHIFT with no bubble.
REQ-020 End of copy with repeats_left>1 and gap_len>0 -> GAP for exactly gap_len cycles with out=0, out_valid=1, busy=1, then reload and return to SHIFT.
REQ-021 repeats_left decrements once per completed copy; no wrap-around (max repeat_cnt = 2^CNT_W-1).
REQ-022 DONE: frame_done=1, busy=0, out_valid=0, out=0 for one cycle, then IDLE unconditionally.
REQ-023 start ignored in SHIFT, GAP, DONE; latched values unaffected by input changes mid-frame.
REQ-024 Valid cycles per frame = R*PAT_W + (R-1)*gap_len for R>=1.
REQ-025 start held high continuously: a new frame is accepted in the first IDLE cycle after DONE.

Reset
REQ-026 rst=1 forces IDLE immediately (no clock needed), clearing all registers; out, out_valid, busy, frame_done = 0.
REQ-027 rst asserted mid-frame aborts it; no frame_done is issued for the aborted frame.
REQ-028 After rst deasserts, the first possible start acceptance is the next rising edge.

Structure
REQ-029 Shared package seq_gen_pkg holds the state enum (IDLE, SHIFT, GAP, DONE) and the PAT_W/CNT_W defaults.
REQ-030 One sub-module, piso_shreg (parallel load, shift enable, MSB out), holds the pattern; FSM and counters stay in seq_pattern_gen.

Verification
REQ-031 pattern=1101, repeat_cnt=3, gap_len=0 -> out=110111011101 over 12 consecutive valid cycles, frame_done in cycle 13.
REQ-032 pattern=1101, repeat_cnt=2, gap_len=2 -> out=1101001101 over 10 valid cycles, frame_done in the next cycle.
REQ-033 repeat_cnt=0 with start -> out_valid never high, frame_done pulses one cycle after start edge, busy stays 0.
REQ-034 rst pulsed during 2nd bit of SHIFT -> all outputs 0 asynchronously; no frame_done; next start produces a complete frame.
REQ-035 start re-pulsed with pattern=0000 during busy -> ignored; original 1101 frame completes unchanged.
REQ-036 Loopback into the team's Moore 1101 non-overlapping detector, repeat_cnt=4, gap_len=1 -> exactly 4 detector out pulses.
